// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply/divide engine: shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied on the final iteration.
module multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] hi_reg, hi_next;   // product high half / partial remainder
    logic [WIDTH-1:0] lo_reg, lo_next;   // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] op_reg, op_next;   // multiplicand / divisor magnitude
    logic             sign_reg, sign_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             exc_reg, exc_next;
    logic             rdy_reg, rdy_next;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               sign_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi, mul_lo;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic               mul_ovf;
    logic [WIDTH-1:0]   div_shift, div_rem, div_quo, quot;
    logic [WIDTH:0]     trial;
    logic               div_ovf;

    // The most negative operand maps to 2^31, which is still representable unsigned.
    assign abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign sign_in = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];

    assign mul_sum  = {1'b0, hi_reg} + {1'b0, {WIDTH{lo_reg[0]}} & op_reg};
    assign mul_hi   = mul_sum[WIDTH:1];
    assign mul_lo   = {mul_sum[0], lo_reg[WIDTH-1:1]};
    assign prod_mag = {mul_hi, mul_lo};
    assign prod     = sign_reg ? -prod_mag : prod_mag;
    // Overflow when the upper word is not a pure sign extension of bit 31.
    assign mul_ovf  = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));

    // Remainder stays below the divisor (<= 2^31), so its top bit is always zero.
    assign div_shift = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
    assign trial     = {1'b0, div_shift} - {1'b0, op_reg};
    assign div_rem   = trial[WIDTH] ? div_shift : trial[WIDTH-1:0];
    assign div_quo   = {lo_reg[WIDTH-2:0], ~trial[WIDTH]};
    assign quot      = sign_reg ? -div_quo : div_quo;
    // A positive quotient of 2^31 only arises from 0x80000000 / -1.
    assign div_ovf   = ~sign_reg & div_quo[WIDTH-1];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            op_reg     <= '0;
            sign_reg   <= 1'b0;
            result_reg <= '0;
            exc_reg    <= 1'b0;
            rdy_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            op_reg     <= op_next;
            sign_reg   <= sign_next;
            result_reg <= result_next;
            exc_reg    <= exc_next;
            rdy_reg    <= rdy_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        op_next     = op_reg;
        sign_next   = sign_reg;
        result_next = result_reg;
        exc_next    = exc_reg;
        rdy_next    = 1'b0;

        case (state_reg)
            MULT: begin
                hi_next    = mul_hi;
                lo_next    = mul_lo;
                count_next = count_reg + CW'(1);
                if (count_reg == LAST) begin
                    state_next  = DONE;
                    result_next = prod[WIDTH-1:0];
                    exc_next    = mul_ovf;
                    rdy_next    = 1'b1;
                end
            end
            DIV: begin
                hi_next    = div_rem;
                lo_next    = div_quo;
                count_next = count_reg + CW'(1);
                if (count_reg == LAST) begin
                    state_next  = DONE;
                    result_next = quot;
                    exc_next    = div_ovf;
                    rdy_next    = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // A start overrides whatever the current state computed, including a
        // completion on the same edge: the aborted result is never published.
        if (ctrl_MULT) begin
            state_next  = MULT;
            count_next  = '0;
            hi_next     = '0;
            lo_next     = abs_b;
            op_next     = abs_a;
            sign_next   = sign_in;
            result_next = result_reg;
            exc_next    = exc_reg;
            rdy_next    = 1'b0;
        end else if (ctrl_DIV) begin
            count_next = '0;
            hi_next    = '0;
            lo_next    = abs_a;
            op_next    = abs_b;
            sign_next  = sign_in;
            if (data_operandB == '0) begin
                state_next  = DONE;
                result_next = '0;
                exc_next    = 1'b1;
                rdy_next    = 1'b1;
            end else begin
                state_next  = DIV;
                result_next = result_reg;
                exc_next    = exc_reg;
                rdy_next    = 1'b0;
            end
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;
    assign busy           = (state_reg == MULT) || (state_reg == DIV);

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard-driven bench for multdiv_iter: expectations are queued at start and
// checked when data_resultRDY appears, together with the observed latency.
module tb_multdiv_iter;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    multdiv_iter #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .clr_n(clr_n),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference built on the simulator's signed arithmetic.
    function automatic exp_t model(bit is_mult, logic [31:0] x, logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        int          q;
        e.lat = 32;
        if (is_mult) begin
            p     = longint'($signed(x)) * longint'($signed(y));
            e.res = p[31:0];
            e.exc = !(p[63:31] == '0 || p[63:31] == '1);
        end else if (y == 32'd0) begin
            e.res = '0;
            e.exc = 1'b1;
            e.lat = 0;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            q     = $signed(x) / $signed(y);
            e.res = q;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Drives a one-cycle start; returns just after the sampling edge E0.
    task automatic start(bit mm, bit dd, logic [31:0] x, logic [31:0] y);
        @(negedge clk);
        data_operandA = x;
        data_operandB = y;
        ctrl_MULT     = mm;
        ctrl_DIV      = dd;
        @(posedge clk);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    // Returns the number of edges after E0 at which RDY was seen (101 on timeout).
    task automatic wait_rdy(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) break;
            lat++;
            if (lat > 100) break;
        end
    endtask

    task automatic count_rdy(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (data_resultRDY === 1'b1) n++;
        end
    endtask

    task automatic test_reset;
        exp_t e;
        int   lat, n;
        repeat (2) @(negedge clk);
        compared += 4;
        if (data_result !== 32'd0) begin mismatched++; $display("FAIL reset_result got %h want 0", data_result); end
        if (data_exception !== 1'b0) begin mismatched++; $display("FAIL reset_exc got %b want 0", data_exception); end
        if (data_resultRDY !== 1'b0) begin mismatched++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", busy); end
        clr_n = 1'b1;

        sb.push_back('{res: 32'd14, exc: 1'b0, lat: 32});
        start(1'b0, 1'b1, 32'd100, 32'd7);
        wait_rdy(lat);
        e = sb.pop_front();
        compared += 2;
        $display("div 100/7 -> %h exc %b lat %0d", data_result, data_exception, lat);
        if (data_result !== e.res) begin mismatched++; $display("FAIL pre_reset_div got %h want %h", data_result, e.res); end
        if (lat !== e.lat) begin mismatched++; $display("FAIL pre_reset_lat got %0d want %0d", lat, e.lat); end

        start(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        compared += 4;
        $display("reset asserted mid-div: result %h exc %b rdy %b busy %b", data_result, data_exception, data_resultRDY, busy);
        if (data_result !== 32'd0) begin mismatched++; $display("FAIL midreset_result got %h want 0", data_result); end
        if (data_exception !== 1'b0) begin mismatched++; $display("FAIL midreset_exc got %b want 0", data_exception); end
        if (data_resultRDY !== 1'b0) begin mismatched++; $display("FAIL midreset_rdy got %b want 0", data_resultRDY); end
        if (busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy got %b want 0", busy); end
        @(negedge clk);
        clr_n = 1'b1;
        count_rdy(40, n);
        compared++;
        if (n !== 0) begin mismatched++; $display("FAIL postreset_rdy got %0d pulses want 0", n); end

        sb.push_back('{res: 32'd1, exc: 1'b0, lat: 32});
        start(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rdy(lat);
        e = sb.pop_front();
        compared += 3;
        $display("mult -1*-1 -> %h exc %b lat %0d", data_result, data_exception, lat);
        if (data_result !== e.res) begin mismatched++; $display("FAIL mult_m1_result got %h want %h", data_result, e.res); end
        if (data_exception !== e.exc) begin mismatched++; $display("FAIL mult_m1_exc got %b want %b", data_exception, e.exc); end
        if (lat !== e.lat) begin mismatched++; $display("FAIL mult_m1_lat got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_mult;
        exp_t        e;
        int          lat;
        logic [31:0] ta [2];
        logic [31:0] tb [2];
        exp_t        te [2];
        sb.push_back('{res: 32'd42, exc: 1'b0, lat: 32});
        start(1'b1, 1'b0, 32'd6, 32'd7);
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            compared += 2;
            if (busy !== (k < 32)) begin mismatched++; $display("FAIL mult_busy k=%0d got %b want %b", k, busy, (k < 32)); end
            if (data_resultRDY !== (k == 32)) begin mismatched++; $display("FAIL mult_rdy k=%0d got %b want %b", k, data_resultRDY, (k == 32)); end
        end
        e = sb.pop_front();
        compared += 2;
        $display("mult 6*7 -> %h exc %b", data_result, data_exception);
        if (data_result !== e.res) begin mismatched++; $display("FAIL mult_6x7 got %h want %h", data_result, e.res); end
        if (data_exception !== e.exc) begin mismatched++; $display("FAIL mult_6x7_exc got %b want %b", data_exception, e.exc); end
        @(negedge clk);
        compared++;
        if (data_resultRDY !== 1'b0) begin mismatched++; $display("FAIL mult_rdy_drop got %b want 0", data_resultRDY); end

        ta = '{32'hFFFF_FFFD, 32'h0001_0000};
        tb = '{32'd5, 32'h0001_0000};
        te = '{'{res: 32'hFFFF_FFF1, exc: 1'b0, lat: 32}, '{res: 32'h0, exc: 1'b1, lat: 32}};
        for (int i = 0; i < 2; i++) begin
            sb.push_back(te[i]);
            start(1'b1, 1'b0, ta[i], tb[i]);
            wait_rdy(lat);
            e = sb.pop_front();
            compared += 3;
            $display("mult %h*%h -> %h exc %b lat %0d", ta[i], tb[i], data_result, data_exception, lat);
            if (data_result !== e.res) begin mismatched++; $display("FAIL mult_result[%0d] got %h want %h", i, data_result, e.res); end
            if (data_exception !== e.exc) begin mismatched++; $display("FAIL mult_exc[%0d] got %b want %b", i, data_exception, e.exc); end
            if (lat !== e.lat) begin mismatched++; $display("FAIL mult_lat[%0d] got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_div;
        exp_t        e;
        int          lat;
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        exp_t        te [5];
        ta = '{32'd100, 32'hFFFF_FF9C, 32'd7, 32'd5, 32'h8000_0000};
        tb = '{32'd7, 32'd7, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF};
        te = '{'{res: 32'd14, exc: 1'b0, lat: 32},
               '{res: 32'hFFFF_FFF2, exc: 1'b0, lat: 32},
               '{res: 32'd0, exc: 1'b0, lat: 32},
               '{res: 32'd0, exc: 1'b1, lat: 0},
               '{res: 32'h8000_0000, exc: 1'b1, lat: 32}};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(te[i]);
            start(1'b0, 1'b1, ta[i], tb[i]);
            wait_rdy(lat);
            e = sb.pop_front();
            compared += 3;
            $display("div %h/%h -> %h exc %b lat %0d", ta[i], tb[i], data_result, data_exception, lat);
            if (data_result !== e.res) begin mismatched++; $display("FAIL div_result[%0d] got %h want %h", i, data_result, e.res); end
            if (data_exception !== e.exc) begin mismatched++; $display("FAIL div_exc[%0d] got %b want %b", i, data_exception, e.exc); end
            if (lat !== e.lat) begin mismatched++; $display("FAIL div_lat[%0d] got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_abort;
        exp_t e;
        int   lat, n;
        start(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        sb.push_back('{res: 32'd3, exc: 1'b0, lat: 32});
        start(1'b0, 1'b1, 32'd9, 32'd3);
        wait_rdy(lat);
        e = sb.pop_front();
        compared += 3;
        $display("abort mult, div 9/3 -> %h exc %b lat %0d", data_result, data_exception, lat);
        if (data_result !== e.res) begin mismatched++; $display("FAIL abort_result got %h want %h", data_result, e.res); end
        if (data_exception !== e.exc) begin mismatched++; $display("FAIL abort_exc got %b want %b", data_exception, e.exc); end
        if (lat !== e.lat) begin mismatched++; $display("FAIL abort_lat got %0d want %0d", lat, e.lat); end
        count_rdy(40, n);
        compared++;
        if (n !== 0) begin mismatched++; $display("FAIL abort_extra_rdy got %0d pulses want 0", n); end
    endtask

    task automatic test_both_starts;
        exp_t e;
        int   lat;
        sb.push_back('{res: 32'd12, exc: 1'b0, lat: 32});
        start(1'b1, 1'b1, 32'd6, 32'd2);
        wait_rdy(lat);
        e = sb.pop_front();
        compared += 2;
        $display("mult+div 6,2 -> %h exc %b lat %0d", data_result, data_exception, lat);
        if (data_result !== e.res) begin mismatched++; $display("FAIL both_result got %h want %h", data_result, e.res); end
        if (lat !== e.lat) begin mismatched++; $display("FAIL both_lat got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_hold;
        exp_t e;
        int   lat;
        sb.push_back('{res: 32'd14, exc: 1'b0, lat: 32});
        start(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        compared++;
        $display("hold during div: result %h", data_result);
        if (data_result !== 32'd12) begin mismatched++; $display("FAIL hold_result got %h want 0000000c", data_result); end
        wait_rdy(lat);
        e = sb.pop_front();
        compared++;
        if (data_result !== e.res) begin mismatched++; $display("FAIL hold_final got %h want %h", data_result, e.res); end
    endtask

    task automatic test_random;
        exp_t        e;
        int          lat;
        bit          mm;
        logic [31:0] x, y;
        for (int i = 0; i < 10; i++) begin
            mm = 1'($urandom_range(0, 1));
            x  = $urandom;
            y  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            if (i == 4) begin mm = 1'b0; y = 32'd0; end
            sb.push_back(model(mm, x, y));
            start(mm, !mm, x, y);
            wait_rdy(lat);
            e = sb.pop_front();
            compared += 3;
            $display("rand %s %h,%h -> %h exc %b lat %0d", mm ? "mult" : "div", x, y, data_result, data_exception, lat);
            if (data_result !== e.res) begin mismatched++; $display("FAIL rand_result[%0d] got %h want %h", i, data_result, e.res); end
            if (data_exception !== e.exc) begin mismatched++; $display("FAIL rand_exc[%0d] got %b want %b", i, data_exception, e.exc); end
            if (lat !== e.lat) begin mismatched++; $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_abort();
        test_both_starts();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
